ef_psram_qspi_responder: RTL and testbench



---
 rtl/ef_psram_qspi_responder.sv | 156 +++++++++++++++
 tb/tb_ef_psram_qspi_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ef_psram_qspi_responder.sv
// rtl/ef_psram_qspi_responder.sv - quad-SPI PSRAM device model serving EBh quad reads and 38h quad writes
// Define EF_PSRAM_RESP_STATS_EN to add the rd_cnt/wr_cnt/bad_cmd_cnt transaction counters.
module ef_psram_qspi_responder #(
   parameter int         AW          = 10,
   parameter int         WAIT_CYCLES = 6,
   parameter logic [7:0] MEM_INIT    = 8'h00
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sck,
   input  logic        ce_n,
   input  logic [3:0]  din,
   output logic [3:0]  dout,
   output logic [3:0]  douten,
   output logic        busy
`ifdef EF_PSRAM_RESP_STATS_EN
   ,
   output logic [15:0] rd_cnt,
   output logic [15:0] wr_cnt,
   output logic [15:0] bad_cmd_cnt
`endif
);
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE} state_t;

   state_t        state, state_nx;
   logic          sck_q, sck_qq, ce_n_q;
   logic [3:0]    din_q;
   logic [6:0]    cmd;
   logic [7:0]    cnt;
   logic          is_rd, wr_hi, rd_lo, rd_started;
   logic [3:0]    held, dout_q;
   logic [AW-1:0] ptr;
   logic [7:0]    mem [2**AW];

   logic          sck_rise, sck_fall, wr_en;
   logic [7:0]    cmd_nx, rd_byte;
   logic [AW-1:0] ptr_shift;

   assign sck_rise  = ~ce_n_q & sck_q & ~sck_qq;
   assign sck_fall  = ~ce_n_q & ~sck_q & sck_qq;
   assign cmd_nx    = {cmd, din_q[0]};
   // Address bits above AW fall off the top of the shift.
   assign ptr_shift = AW'({ptr, din_q});
   assign wr_en     = (state == S_WDATA) && sck_rise && !wr_hi;
   // Storage holds data XOR MEM_INIT, so zero power-up contents read back as MEM_INIT.
   assign rd_byte   = mem[ptr] ^ MEM_INIT;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_q  <= 1'b0;
         sck_qq <= 1'b0;
         ce_n_q <= 1'b1;
         din_q  <= 4'h0;
      end else begin
         sck_q  <= sck;
         sck_qq <= sck_q;
         ce_n_q <= ce_n;
         din_q  <= din;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (ce_n_q) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: state_nx = S_CMD;
            S_CMD:
               if (sck_rise && cnt == 8'd7)
                  state_nx = (cmd_nx == 8'hEB || cmd_nx == 8'h38) ? S_ADDR : S_IGNORE;
            S_ADDR:
               if (sck_rise && cnt == 8'd5)
                  state_nx = is_rd ? S_WAIT : S_WDATA;
            S_WAIT:
               if (sck_rise && cnt == 8'(WAIT_CYCLES - 1))
                  state_nx = S_RDATA;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy   = (state != S_IDLE);
      douten = (state == S_RDATA && rd_started) ? 4'hF : 4'h0;
      dout   = dout_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt        <= 8'd0;
         cmd        <= 7'd0;
         is_rd      <= 1'b0;
         ptr        <= '0;
         held       <= 4'h0;
         wr_hi      <= 1'b1;
         rd_lo      <= 1'b0;
         rd_started <= 1'b0;
         dout_q     <= 4'h0;
      end else begin
         if (state_nx != state) cnt <= 8'd0;
         else if (sck_rise)     cnt <= cnt + 8'd1;

         if (state == S_CMD && sck_rise) begin
            cmd   <= cmd_nx[6:0];
            is_rd <= (cmd_nx == 8'hEB);
         end
         if (state == S_ADDR && sck_rise) ptr <= ptr_shift;

         if (state != S_WDATA) begin
            wr_hi <= 1'b1;
         end else if (sck_rise) begin
            wr_hi <= ~wr_hi;
            if (wr_hi) held <= din_q;
            else       ptr  <= ptr + 1'b1;
         end

         // First fall in RDATA presents the high nibble of the start byte.
         if (state != S_RDATA) begin
            rd_lo      <= 1'b0;
            rd_started <= 1'b0;
         end else if (sck_fall) begin
            rd_lo      <= ~rd_lo;
            rd_started <= 1'b1;
            dout_q     <= rd_lo ? rd_byte[3:0] : rd_byte[7:4];
            if (rd_lo) ptr <= ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_en) mem[ptr] <= {held, din_q} ^ MEM_INIT;
   end

`ifdef EF_PSRAM_RESP_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_cnt      <= 16'd0;
         wr_cnt      <= 16'd0;
         bad_cmd_cnt <= 16'd0;
      end else begin
         if (state_nx == S_WAIT && state != S_WAIT && rd_cnt != 16'hFFFF)
            rd_cnt <= rd_cnt + 16'd1;
         if (wr_en && wr_cnt != 16'hFFFF)
            wr_cnt <= wr_cnt + 16'd1;
         if (state_nx == S_IGNORE && state != S_IGNORE && bad_cmd_cnt != 16'hFFFF)
            bad_cmd_cnt <= bad_cmd_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ef_psram_qspi_responder.sv
// tb/tb_ef_psram_qspi_responder.sv - self-checking bench for ef_psram_qspi_responder against a byte-array model
module tb_ef_psram_qspi_responder;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;
   localparam int WAITC = 6;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       sck  = 1'b0;
   logic       ce_n = 1'b1;
   logic [3:0] din  = 4'h0;
   logic [3:0] dout, douten;
   logic       busy;
`ifdef EF_PSRAM_RESP_STATS_EN
   logic [15:0] rd_cnt, wr_cnt, bad_cmd_cnt;
   int exp_rd = 0, exp_wr = 0, exp_bad = 0;
`endif

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] ref_mem [DEPTH];
   logic [7:0] wq [$];
   logic [3:0] en_acc;
   logic [3:0] q, e;

   always #5 clk = ~clk;

   ef_psram_qspi_responder #(.AW(AW), .WAIT_CYCLES(WAITC), .MEM_INIT(8'h00)) dut (
      .clk_i(clk), .rst_i(rst), .sck(sck), .ce_n(ce_n), .din(din),
      .dout(dout), .douten(douten), .busy(busy)
`ifdef EF_PSRAM_RESP_STATS_EN
      , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .bad_cmd_cnt(bad_cmd_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One sck period: drive d, sample outputs late in the low phase, then rise and fall.
   task automatic pulse(input logic [3:0] d, output logic [3:0] dq, output logic [3:0] en);
      din = d;
      repeat (4) @(negedge clk);
      dq  = dout;
      en  = douten;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic begin_txn(input logic [7:0] c);
      ce_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 7; i >= 0; i--) begin
         pulse({3'b000, c[i]}, q, e);
         en_acc |= e;
      end
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 5; i >= 0; i--) begin
         pulse(a[i*4 +: 4], q, e);
         en_acc |= e;
      end
   endtask

   task automatic end_txn();
      ce_n = 1'b1;
      din  = 4'h0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_write(input logic [23:0] a, input string tag);
      en_acc = 4'h0;
      begin_txn(8'h38);
      send_addr(a);
      foreach (wq[i]) begin
         pulse(wq[i][7:4], q, e);
         en_acc |= e;
         pulse(wq[i][3:0], q, e);
         en_acc |= e;
      end
      end_txn();
      check({tag, "_douten"}, 32'(en_acc), 32'h0);
      foreach (wq[i]) ref_mem[(int'(a) + i) % DEPTH] = wq[i];
`ifdef EF_PSRAM_RESP_STATS_EN
      exp_wr += wq.size();
`endif
   endtask

   task automatic do_read(input logic [23:0] a, input int nn, input string tag, input bit keep_open);
      logic [7:0] b;
      logic [3:0] exp_n;
      en_acc = 4'h0;
      begin_txn(8'hEB);
      send_addr(a);
      for (int i = 0; i < WAITC; i++) begin
         pulse(4'h0, q, e);
         en_acc |= e;
      end
      check({tag, "_pre_douten"}, 32'(en_acc), 32'h0);
      for (int i = 0; i < nn; i++) begin
         b     = ref_mem[(int'(a) + i / 2) % DEPTH];
         exp_n = (i % 2 == 0) ? b[7:4] : b[3:0];
         pulse($urandom_range(0, 15), q, e);
         check($sformatf("%s_nib%0d", tag, i), 32'({e, q}), 32'({4'hF, exp_n}));
      end
      if (!keep_open) end_txn();
`ifdef EF_PSRAM_RESP_STATS_EN
      exp_rd++;
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [23:0] a;
      int n, off;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

      // reset with sck toggling
      @(negedge clk); sck = 1'b1;
      @(negedge clk); sck = 1'b0; rst = 1'b0;
      check("reset_dout", 32'(dout), 32'h0);
      check("reset_douten", 32'(douten), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 32'h0);
      ce_n = 1'b0;
      repeat (2) @(negedge clk);
      check("ce_busy", 32'(busy), 32'h1);
      end_txn();
`ifdef EF_PSRAM_RESP_STATS_EN
      check("stats_reset", 32'({rd_cnt, wr_cnt}), 32'h0);
`endif

      wq = '{8'h96, 8'h69};
      do_write(24'h000014, "pre_wr");
      wq = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
      do_write(24'h000010, "wr10");
      do_read(24'h000011, 8, "rd11", 1'b0);

      wq = '{8'h11, 8'h22};
      do_write(24'h0003FF, "wrap_wr");
      do_read(24'h0003FF, 4, "wrap_rd", 1'b0);

      // illegal command followed by free-running sck
      en_acc = 4'h0;
      begin_txn(8'h9F);
      for (int i = 0; i < 20; i++) begin
         pulse(4'($urandom), q, e);
         en_acc |= e;
      end
      check("bad_busy", 32'(busy), 32'h1);
      end_txn();
      check("bad_douten", 32'(en_acc), 32'h0);
`ifdef EF_PSRAM_RESP_STATS_EN
      exp_bad++;
`endif
      do_read(24'h000010, 12, "bad_mem", 1'b0);

      // write aborted after three data nibbles
      wq = '{8'h00, 8'hB4};
      do_write(24'h000020, "ab_pre");
      en_acc = 4'h0;
      begin_txn(8'h38);
      send_addr(24'h000020);
      pulse(4'h7, q, e);
      pulse(4'hE, q, e);
      pulse(4'h9, q, e);
      end_txn();
      ref_mem[32'h20] = 8'h7E;
`ifdef EF_PSRAM_RESP_STATS_EN
      exp_wr++;
      check("stats_rd", 32'(rd_cnt), 32'(exp_rd));
      check("stats_wr", 32'(wr_cnt), 32'(exp_wr));
      check("stats_bad", 32'(bad_cmd_cnt), 32'(exp_bad));
`endif
      do_read(24'h000020, 4, "ab_rd", 1'b0);

      for (int t = 0; t < 6; t++) begin
         a = 24'($urandom);
         n = $urandom_range(1, 6);
         wq.delete();
         for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
         do_write(a, "rnd_wr");
         off = $urandom_range(0, n - 1);
         do_read(a + 24'(off), 2 * (n - off), "rnd_rd", 1'b0);
      end

      // reset in the middle of a read burst
      do_read(24'h000010, 3, "mid_rd", 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_douten", 32'(douten), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      rst  = 1'b0;
      ce_n = 1'b1;
      repeat (4) @(negedge clk);
`ifdef EF_PSRAM_RESP_STATS_EN
      exp_rd = 0; exp_wr = 0; exp_bad = 0;
`endif
      do_read(24'h000011, 8, "post_rst", 1'b0);
`ifdef EF_PSRAM_RESP_STATS_EN
      check("stats_final_rd", 32'(rd_cnt), 32'(exp_rd));
      check("stats_final_wr", 32'(wr_cnt), 32'(exp_wr));
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
